// File: rtl/node_fifo_validready.sv
// -----------------------------------------------------------------------------
// node_fifo_validready
//
// Synchronous FIFO stage with valid/ready handshakes on both sides. It sits
// behind a pipelined valid/ready node and absorbs the beat that is still in
// flight when that node sees ready drop, plus downstream backpressure bursts.
// up_ready_out is a flop and depends only on FIFO occupancy, so there is no
// combinational path from dn_ready_in to up_ready_out.
//
// Optional feature (macro NODE_FIFO_BYPASS_EN):
//   When the FIFO is empty, an upstream beat is also presented to downstream
//   in the same cycle. If downstream takes it, the beat is never written.
//   This adds combinational valid/data paths from input to output. The ready
//   path is unchanged. With the macro undefined, every output comes from
//   registered state.
//
// Parameters:
//   WIDTH - payload width in bits
//   DEPTH - number of entries (power of two, >= 2)
//
// Ports:
//   clk           clock; all state updates on the rising edge
//   rst           asynchronous active-high reset
//   data_in       payload from upstream
//   up_valid_in   upstream valid
//   up_ready_out  to upstream: registered, high when FIFO is not full
//   data_out      payload to downstream (zero when dn_valid_out is low)
//   dn_valid_out  to downstream: an entry is available
//   dn_ready_in   downstream ready
//   count         current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module node_fifo_validready #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     up_valid_in,
    output logic                     up_ready_out,
    output logic [WIDTH-1:0]         data_out,
    output logic                     dn_valid_out,
    input  logic                     dn_ready_in,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);  // index bits
    localparam int PW = AW + 1;         // pointer bits, MSB is the wrap bit

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q,  count_d;
    logic          ready_q,  ready_d;

    logic          empty;
    logic          full;
    logic          push;
    logic          pop_mem;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];

    // Same index with different wrap bits means the write pointer has lapped
    // the read pointer exactly once.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

`ifdef NODE_FIFO_BYPASS_EN
    logic bypass;

    // ready_q gates the bypass too: a beat upstream is not allowed to hand
    // over (for example during the first cycle after reset) must not leak out.
    assign bypass       = empty & up_valid_in & ready_q & dn_ready_in;
    assign dn_valid_out = empty ? (up_valid_in & ready_q) : 1'b1;
    assign data_out     = !empty      ? mem[rd_idx] :
                          dn_valid_out ? data_in     : '0;
    // A bypassed beat is consumed directly and never touches storage.
    assign push         = up_valid_in & ready_q & ~full & ~bypass;
`else
    assign dn_valid_out = !empty;
    assign data_out     = dn_valid_out ? mem[rd_idx] : '0;
    // ~full is redundant with ready_q; it keeps storage safe regardless.
    assign push         = up_valid_in & ready_q & ~full;
`endif

    // Only stored entries are popped from memory.
    assign pop_mem = ~empty & dn_ready_in;

    // NOTE: every signal assigned in always_comb gets a default on entry, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_mem) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + PW'(push) - PW'(pop_mem);
        // Ready looks at next occupancy, so a pop while full only reopens the
        // input on the following cycle (one bubble, no comb ready path).
        ready_d = (count_d != PW'(DEPTH));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // NOTE: storage has no reset; the pointers define which entries are
    // valid and data_out is forced to zero when nothing is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= data_in;
        end
    end

    assign up_ready_out = ready_q;
    assign count        = count_q;

endmodule

// File: tb/tb_node_fifo_validready.sv
// -----------------------------------------------------------------------------
// tb_node_fifo_validready
//
// Directed self-checking bench for node_fifo_validready (WIDTH=32, DEPTH=4).
// Inputs are driven 1 time unit after each rising edge. Outputs are sampled on
// the falling edge. Expected values come from hand-derived constants and, for
// the randomised phase, from a queue model of the FIFO.
// -----------------------------------------------------------------------------
module tb_node_fifo_validready;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             up_valid_in;
    logic             up_ready_out;
    logic [WIDTH-1:0] data_out;
    logic             dn_valid_out;
    logic             dn_ready_in;
    logic [2:0]       count;

    int checks   = 0;
    int failures = 0;

    // Queue model used in the randomised phase.
    logic [WIDTH-1:0] q[$];
    logic             ready_m;
    logic             hold;

    node_fifo_validready #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .up_valid_in  (up_valid_in),
        .up_ready_out (up_ready_out),
        .data_out     (data_out),
        .dn_valid_out (dn_valid_out),
        .dn_ready_in  (dn_ready_in),
        .count        (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // One model step, called at the sample point after the inputs are set.
    task automatic model_cycle();
        logic dn_valid_m;
        logic push_m;
        logic pop_m;
        logic [WIDTH-1:0] exp_data;
        push_m = up_valid_in & ready_m;
`ifdef NODE_FIFO_BYPASS_EN
        dn_valid_m = (q.size() != 0) || push_m;
`else
        dn_valid_m = (q.size() != 0);
`endif
        pop_m = dn_valid_m & dn_ready_in;
        check("rnd_ready", up_ready_out, ready_m);
        check("rnd_valid", dn_valid_out, dn_valid_m);
        check("rnd_count", count, q.size());
        if (push_m) q.push_back(data_in);
        if (pop_m) begin
            exp_data = q.pop_front();
            check("rnd_data", data_out, exp_data);
        end else if (!dn_valid_m) begin
            check("rnd_data_zero", data_out, 0);
        end
        hold    = up_valid_in & ~ready_m;
        ready_m = (q.size() != DEPTH);
    endtask

    initial begin
        rst         = 1'b1;
        data_in     = '0;
        up_valid_in = 1'b0;
        dn_ready_in = 1'b0;

        // ---------------- reset then idle ----------------
        repeat (3) tick();
        mid();
        check("rst_ready", up_ready_out, 0);
        check("rst_valid", dn_valid_out, 0);
        check("rst_count", count, 0);
        check("rst_data", data_out, 0);
        tick();
        rst = 1'b0;
        mid();
        check("rel_ready_before_edge", up_ready_out, 0);
        tick();
        mid();
        check("rel_ready", up_ready_out, 1);
        check("rel_valid", dn_valid_out, 0);

        // ---------------- fill with dn_ready_in = 0 ----------------
        for (int i = 0; i < 4; i++) begin
            tick();
            up_valid_in = 1'b1;
            data_in     = 32'hA0 + i;
            mid();
            check("fill_count", count, i);
            check("fill_ready", up_ready_out, 1);
        end
        tick();
        data_in = 32'hA4;  // held valid, must not be accepted
        mid();
        check("full_count", count, 4);
        check("full_ready", up_ready_out, 0);
        check("full_valid", dn_valid_out, 1);
        check("full_data", data_out, 32'hA0);
        tick();
        mid();
        check("full_hold_count", count, 4);
        check("full_hold_data", data_out, 32'hA0);

        // ---------------- drain order ----------------
        tick();
        dn_ready_in = 1'b1;
        mid();
        check("drain0_data", data_out, 32'hA0);
        check("drain0_ready", up_ready_out, 0);
        tick();
        mid();
        check("drain1_data", data_out, 32'hA1);
        check("drain1_count", count, 3);
        check("drain1_ready", up_ready_out, 1);
        tick();             // 0xA4 accepted at this edge
        up_valid_in = 1'b0;
        mid();
        check("drain2_data", data_out, 32'hA2);
        check("drain2_count", count, 3);
        tick();
        mid();
        check("drain3_data", data_out, 32'hA3);
        check("drain3_count", count, 2);
        tick();
        mid();
        check("drain4_data", data_out, 32'hA4);
        check("drain4_count", count, 1);
        tick();
        mid();
        check("drained_valid", dn_valid_out, 0);
        check("drained_count", count, 0);
        check("drained_data", data_out, 0);

        // ---------------- streaming with wrap ----------------
        for (int i = 0; i < 20; i++) begin
            tick();
            up_valid_in = 1'b1;
            data_in     = 32'h100 + i;
            mid();
            check("stream_ready", up_ready_out, 1);
`ifdef NODE_FIFO_BYPASS_EN
            check("stream_valid", dn_valid_out, 1);
            check("stream_data", data_out, 32'h100 + i);
            check("stream_count", count, 0);
`else
            if (i == 0) begin
                check("stream_first_valid", dn_valid_out, 0);
            end else begin
                check("stream_valid", dn_valid_out, 1);
                check("stream_data", data_out, 32'h100 + i - 1);
                check("stream_count", count, 1);
            end
`endif
        end
        tick();
        up_valid_in = 1'b0;
        mid();
`ifdef NODE_FIFO_BYPASS_EN
        check("stream_tail_valid", dn_valid_out, 0);
`else
        check("stream_tail_data", data_out, 32'h113);
        check("stream_tail_valid", dn_valid_out, 1);
`endif
        tick();
        mid();
        check("stream_end_valid", dn_valid_out, 0);
        check("stream_end_count", count, 0);

        // ---------------- random backpressure ----------------
        ready_m = 1'b1;
        hold    = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (!hold) begin
                up_valid_in = 1'($urandom_range(0, 1));
                data_in     = $urandom;
            end
            dn_ready_in = 1'($urandom_range(0, 1));
            mid();
            model_cycle();
        end
        begin
            int budget;
            budget = 0;
            while ((q.size() != 0 || hold) && budget < 50) begin
                tick();
                if (!hold) up_valid_in = 1'b0;
                dn_ready_in = 1'b1;
                mid();
                model_cycle();
                budget++;
            end
            check("rnd_drain_left", q.size(), 0);
        end

        // ---------------- reset mid-stream ----------------
        tick();
        up_valid_in = 1'b0;
        dn_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            up_valid_in = 1'b1;
            data_in     = 32'hC0 + i;
            mid();
        end
        tick();
        up_valid_in = 1'b0;
        mid();
        check("pre_rst_count", count, 3);
        check("pre_rst_valid", dn_valid_out, 1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", dn_valid_out, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_ready", up_ready_out, 0);
        check("mid_rst_data", data_out, 0);
        tick();
        rst = 1'b0;
        tick();
        mid();
        check("post_rst_ready", up_ready_out, 1);
        check("post_rst_valid", dn_valid_out, 0);
        tick();
        up_valid_in = 1'b1;
        data_in     = 32'hBEEF;
        dn_ready_in = 1'b1;
        mid();
`ifdef NODE_FIFO_BYPASS_EN
        check("beef_valid", dn_valid_out, 1);
        check("beef_data", data_out, 32'hBEEF);
`else
        check("beef_pre_valid", dn_valid_out, 0);
`endif
        tick();
        up_valid_in = 1'b0;
        mid();
`ifdef NODE_FIFO_BYPASS_EN
        check("beef_gone_valid", dn_valid_out, 0);
`else
        check("beef_valid", dn_valid_out, 1);
        check("beef_data", data_out, 32'hBEEF);
`endif
        tick();
        mid();
        check("beef_end_valid", dn_valid_out, 0);
        check("beef_end_count", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
